// File: rtl/ex_muldiv_unit_if.sv
// Request/result bundle between the EX-stage pipeline logic and the multiply/divide unit.
interface ex_muldiv_unit_if;
    logic        flush_i;
    logic        valid_i;
    logic [2:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        hi_we_o;
    logic        lo_we_o;

    modport master (
        output flush_i, valid_i, op_i, a_i, b_i,
        input  busy_o, done_o, hi_o, lo_o, hi_we_o, lo_we_o
    );

    modport slave (
        input  flush_i, valid_i, op_i, a_i, b_i,
        output busy_o, done_o, hi_o, lo_o, hi_we_o, lo_we_o
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// EX-stage multi-cycle multiply/divide unit: fixed-latency multiply, 32-step restoring divide,
// single-cycle MTHI/MTLO, with a busy stall request and a one-cycle HI/LO result strobe.
module ex_muldiv_unit #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_ITERS  = 32
) (
    input logic             clk,
    input logic             resetn,
    ex_muldiv_unit_if.slave mdu
);
    localparam int CNT_W = $clog2(DIV_ITERS);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'((MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_ITERS - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} stateT;
    typedef enum logic [2:0] {
        OP_NONE, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_RSVD
    } opT;

    stateT            state, stateNext;
    opT               op;
    logic [CNT_W-1:0] cnt;
    logic             cntLast;
    logic [31:0]      aReg, bReg, remReg, quoReg, divisorMag;
    logic             signedOp, divOp, negQuo, negRem, divZero;
    logic             isMulOp, isDivOp, accept, opSigned;

    assign op       = opT'(mdu.op_i);
    assign isMulOp  = mdu.valid_i && (op == OP_MULT || op == OP_MULTU);
    assign isDivOp  = mdu.valid_i && (op == OP_DIV || op == OP_DIVU);
    assign accept   = (state == IDLE) && (isMulOp || isDivOp) && !mdu.flush_i;
    assign opSigned = (op == OP_MULT) || (op == OP_DIV);
    assign cntLast  = (cnt == ((state == MUL) ? MUL_LAST : DIV_LAST));

    // Product is formed from the latched operands and only consumed in DONE.
    logic signed [32:0] mulA, mulB;
    logic signed [65:0] mulFull;
    assign mulA    = {signedOp & aReg[31], aReg};
    assign mulB    = {signedOp & bReg[31], bReg};
    assign mulFull = mulA * mulB;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    logic [32:0] shifted, trial;
    assign shifted = {remReg, quoReg[31]};
    assign trial   = shifted - {1'b0, divisorMag};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt        <= '0;
            aReg       <= '0;
            bReg       <= '0;
            remReg     <= '0;
            quoReg     <= '0;
            divisorMag <= '0;
            signedOp   <= 1'b0;
            divOp      <= 1'b0;
            negQuo     <= 1'b0;
            negRem     <= 1'b0;
            divZero    <= 1'b0;
        end else if (mdu.flush_i) begin
            cnt <= '0;
        end else if (accept) begin
            cnt        <= '0;
            aReg       <= mdu.a_i;
            bReg       <= mdu.b_i;
            signedOp   <= opSigned;
            divOp      <= isDivOp;
            negQuo     <= opSigned & (mdu.a_i[31] ^ mdu.b_i[31]);
            negRem     <= opSigned & mdu.a_i[31];
            divZero    <= (mdu.b_i == 32'd0);
            remReg     <= '0;
            quoReg     <= (opSigned & mdu.a_i[31]) ? -mdu.a_i : mdu.a_i;
            divisorMag <= (opSigned & mdu.b_i[31]) ? -mdu.b_i : mdu.b_i;
        end else if (state == MUL || state == DIV) begin
            cnt <= cntLast ? '0 : cnt + 1'b1;
            if (state == DIV) begin
                if (!trial[32]) begin
                    remReg <= trial[31:0];
                    quoReg <= {quoReg[30:0], 1'b1};
                end else begin
                    remReg <= shifted[31:0];
                    quoReg <= {quoReg[30:0], 1'b0};
                end
            end
        end
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        stateNext   = state;
        mdu.busy_o  = 1'b0;
        mdu.done_o  = 1'b0;
        mdu.hi_o    = '0;
        mdu.lo_o    = '0;
        mdu.hi_we_o = 1'b0;
        mdu.lo_we_o = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    mdu.busy_o = 1'b1;
                    if (isDivOp)
                        stateNext = DIV;
                    else
                        stateNext = (MUL_CYCLES > 1) ? MUL : DONE;
                end else if (mdu.valid_i && op == OP_MTHI) begin
                    mdu.done_o  = 1'b1;
                    mdu.hi_o    = mdu.a_i;
                    mdu.hi_we_o = 1'b1;
                end else if (mdu.valid_i && op == OP_MTLO) begin
                    mdu.done_o  = 1'b1;
                    mdu.lo_o    = mdu.a_i;
                    mdu.lo_we_o = 1'b1;
                end
            end
            MUL, DIV: begin
                mdu.busy_o = 1'b1;
                if (cntLast)
                    stateNext = DONE;
            end
            DONE: begin
                mdu.done_o  = 1'b1;
                mdu.hi_we_o = 1'b1;
                mdu.lo_we_o = 1'b1;
                stateNext   = IDLE;
                if (!divOp) begin
                    mdu.hi_o = mulFull[63:32];
                    mdu.lo_o = mulFull[31:0];
                end else if (divZero) begin
                    mdu.hi_o = aReg;
                    mdu.lo_o = 32'hFFFF_FFFF;
                end else begin
                    mdu.hi_o = negRem ? -remReg : remReg;
                    mdu.lo_o = negQuo ? -quoReg : quoReg;
                end
            end
            default: stateNext = IDLE;
        endcase
        // A flushed instruction must neither retire nor keep the pipeline stalled.
        if (mdu.flush_i) begin
            stateNext   = IDLE;
            mdu.busy_o  = 1'b0;
            mdu.done_o  = 1'b0;
            mdu.hi_we_o = 1'b0;
            mdu.lo_we_o = 1'b0;
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed corner cases plus random ops on two
// instances (MUL_CYCLES=2 and MUL_CYCLES=1), compared against an arithmetic reference model.
module tb_ex_muldiv_unit;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        sel = 1'b0;
    logic        flush = 1'b0;
    logic        valid = 1'b0;
    logic [2:0]  opR = 3'd0;
    logic [31:0] aR = '0;
    logic [31:0] bR = '0;
    int          nChecks = 0;
    int          nFails = 0;

    ex_muldiv_unit_if bus1 ();
    ex_muldiv_unit_if bus2 ();

    assign bus1.flush_i = flush && !sel;
    assign bus1.valid_i = valid && !sel;
    assign bus1.op_i    = opR;
    assign bus1.a_i     = aR;
    assign bus1.b_i     = bR;
    assign bus2.flush_i = flush && sel;
    assign bus2.valid_i = valid && sel;
    assign bus2.op_i    = opR;
    assign bus2.a_i     = aR;
    assign bus2.b_i     = bR;

    ex_muldiv_unit #(.MUL_CYCLES(2), .DIV_ITERS(32)) dut1 (.clk(clk), .resetn(resetn), .mdu(bus1.slave));
    ex_muldiv_unit #(.MUL_CYCLES(1), .DIV_ITERS(32)) dut2 (.clk(clk), .resetn(resetn), .mdu(bus2.slave));

    always #5 clk = ~clk;

    logic        busyS, doneS, hiWeS, loWeS;
    logic [31:0] hiS, loS;
    assign busyS = sel ? bus2.busy_o  : bus1.busy_o;
    assign doneS = sel ? bus2.done_o  : bus1.done_o;
    assign hiWeS = sel ? bus2.hi_we_o : bus1.hi_we_o;
    assign loWeS = sel ? bus2.lo_we_o : bus1.lo_we_o;
    assign hiS   = sel ? bus2.hi_o    : bus1.hi_o;
    assign loS   = sel ? bus2.lo_o    : bus1.lo_o;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h (sel=%0d op=%0d a=%h b=%h)",
                     tag, obs, exp, sel, opR, aR, bR);
        end
    endtask

    // Architectural result of one MDU instruction, plus cycles from accept to done.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input bit oneCycleMul, output logic [31:0] hi,
                                  output logic [31:0] lo, output logic [1:0] we, output int lat);
        longint      sp;
        logic [63:0] up;
        int          sa, sb, q, r;
        hi = '0; lo = '0; we = 2'b11; lat = 33;
        case (op)
            3'd1: begin
                sp  = longint'($signed(a)) * longint'($signed(b));
                hi  = sp[63:32]; lo = sp[31:0];
                lat = oneCycleMul ? 1 : 2;
            end
            3'd2: begin
                up  = {32'b0, a} * {32'b0, b};
                hi  = up[63:32]; lo = up[31:0];
                lat = oneCycleMul ? 1 : 2;
            end
            3'd3: begin
                sa = $signed(a); sb = $signed(b);
                if (b == 0) begin
                    lo = 32'hFFFF_FFFF; hi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000; hi = 0;
                end else begin
                    q = sa / sb; r = sa % sb;
                    lo = q; hi = r;
                end
            end
            3'd4: begin
                if (b == 0) begin
                    lo = 32'hFFFF_FFFF; hi = a;
                end else begin
                    lo = a / b; hi = a % b;
                end
            end
            3'd5: begin hi = a; we = 2'b10; lat = 0; end
            3'd6: begin lo = a; we = 2'b01; lat = 0; end
            default: begin we = 2'b00; lat = -1; end
        endcase
    endfunction

    // Called just after a rising edge; returns just after a rising edge with valid low.
    task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] expHi, expLo;
        logic [1:0]  expWe;
        int          expLat;
        int          doneAt = -1;
        int          busyCycles = 0;
        model(op, a, b, sel, expHi, expLo, expWe, expLat);
        valid = 1'b1; opR = op; aR = a; bR = b;
        for (int t = 0; t < 40 && doneAt < 0; t++) begin
            @(negedge clk);
            if (doneS) doneAt = t;
            else if (busyS) busyCycles++;
            if (doneAt < 0) begin
                @(posedge clk); #1;
            end
        end
        check("done_latency", doneAt, expLat);
        check("busy_cycles", busyCycles, expLat);
        check("busy_at_done", busyS, 0);
        check("write_enables", {hiWeS, loWeS}, expWe);
        if (expWe[1]) check("hi", hiS, expHi);
        if (expWe[0]) check("lo", loS, expLo);
        @(posedge clk); #1;
        valid = 1'b0;
        @(negedge clk);
        check("idle_after", {busyS, doneS, hiWeS, loWeS}, 0);
        @(posedge clk); #1;
    endtask

    task automatic flushTest();
        int doneSeen = 0;
        sel = 1'b0; valid = 1'b1; opR = 3'd3; aR = 32'hFFFF_FFF9; bR = 32'd2;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (doneS) doneSeen++;
            if (t == 9) check("div_busy_T9", busyS, 1);
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(negedge clk);
        check("flush_outputs", {busyS, doneS, hiWeS, loWeS}, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_no_done", doneSeen, 0);
        runOp(3'd1, 32'hFFFF_FFFD, 32'd7);
    endtask

    task automatic resetTest();
        int activity = 0;
        sel = 1'b0; valid = 1'b1; opR = 3'd3; aR = 32'd1000; bR = 32'd3;
        for (int t = 0; t < 5; t++) begin
            @(posedge clk); #1;
        end
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1; valid = 1'b0;
        @(negedge clk);
        check("reset_midop_outputs", {busyS, doneS, hiWeS, loWeS}, 0);
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (doneS || busyS) activity++;
        end
        check("reset_midop_quiet", activity, 0);
        @(posedge clk); #1;
    endtask

    task automatic reservedTest();
        int activity = 0;
        sel = 1'b0; valid = 1'b1; aR = 32'h1234; bR = 32'h5;
        for (int t = 0; t < 6; t++) begin
            opR = (t < 3) ? 3'd0 : 3'd7;
            @(negedge clk);
            if (busyS || doneS || hiWeS || loWeS) activity++;
            @(posedge clk); #1;
        end
        valid = 1'b0;
        check("none_rsvd_no_effect", activity, 0);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_outputs", {busyS, doneS, hiWeS, loWeS}, 0);
        sel = 1'b1;
        @(negedge clk);
        check("reset_outputs_m1", {busyS, doneS, hiWeS, loWeS}, 0);
        sel = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        runOp(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        runOp(3'd1, 32'hFFFF_FFFD, 32'd7);
        sel = 1'b1;
        runOp(3'd1, 32'hFFFF_FFFD, 32'd7);
        sel = 1'b0;
        runOp(3'd3, 32'hFFFF_FFF9, 32'd2);
        runOp(3'd4, 32'd100, 32'd7);
        runOp(3'd4, 32'd5, 32'd0);
        runOp(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        runOp(3'd3, 32'hFFFF_FFF0, 32'd0);
        runOp(3'd5, 32'h0000_1234, 32'd0);
        runOp(3'd6, 32'hCAFE_F00D, 32'd0);
        flushTest();
        resetTest();
        reservedTest();

        for (int i = 0; i < 40; i++) begin
            sel = 1'($urandom_range(0, 1));
            rop = 3'($urandom_range(1, 6));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: ra = 32'h8000_0000;
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            runOp(rop, ra, rb);
        end
        sel = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage of the 5-stage MIPS pipeline.
- Consumes the MDU op and register operands latched by the ID/EX pipeline register.
- Produces HI/LO results and write enables, which travel down the pipeline to writeback.
- Asserts busy_o while a multi-cycle op occupies EX; hazard logic turns busy_o into StallE/StallD.

Parameters:
MUL_CYCLES, 2, multiply latency in cycles from accept to done_o (legal range 1..8).
DIV_ITERS, 32, restoring-division iterations; fixed at 32 for 32-bit operands.

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
flush_i  in  1  FlushE; abort any op in flight
valid_i  in  1  EX holds a live MDU instruction
op_i  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
a_i  in  32  rs operand (forwarded)
b_i  in  32  rt operand (forwarded)
busy_o  out  1  stall request for EX and upstream stages
done_o  out  1  one-cycle result strobe
hi_o  out  32  HI result, valid when done_o=1
lo_o  out  32  LO result, valid when done_o=1
hi_we_o  out  1  HI write enable, qualified by done_o
lo_we_o  out  1  LO write enable, qualified by done_o

Behaviour:
- Reset/clock: reset is synchronous on resetn=0, with clock clk.
- Reset values: FSM=IDLE, counters=0, operand/result registers=0; busy_o, done_o, hi_we_o, lo_we_o=0.
- FSM states: IDLE, MUL, DIV, DONE.
- Priority: resetn, then flush_i, then normal operation.
- Accept cycle T0: IDLE with valid_i=1 and op in {1..4}.
  - Operands and signedness are latched.
  - busy_o=1 combinationally in T0.
  - Transition to MUL (ops 1,2) or DIV (ops 3,4).
- MTHI/MTLO in IDLE: single cycle, no state change.
  - done_o=1 and busy_o=0 combinationally.
  - hi_o or lo_o = a_i; only the matching write enable is asserted.
- Multiply:
  - 64-bit product; MULT signed, MULTU unsigned; {hi,lo}=product.
  - MUL state counts MUL_CYCLES-1 cycles, then goes to DONE.
  - done_o asserts in cycle T0+MUL_CYCLES.
- Divide:
  - Dividend and divisor are converted to magnitudes at accept.
  - 32 restoring iterations (one quotient bit per cycle) in DIV, cycles T1..T32, then DONE at T0+33.
  - Signed fix-up is applied combinationally in DONE:
    - quotient is negated if the operand signs differ (truncation toward zero);
    - remainder takes the sign of the dividend.
  - lo=quotient, hi=remainder.
- Divide by zero (both DIV and DIVU): lo=32'hFFFFFFFF, hi=a_i as latched.
- DIV overflow case 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0.
- DONE state:
  - done_o=1, busy_o=0, hi_we_o=lo_we_o=1 for ops 1..4.
  - The pipeline advances the completed instruction at the end of this cycle.
  - valid_i is ignored in DONE (it is the same instruction).
  - Next state is always IDLE, so back-to-back MDU ops cost one IDLE accept cycle.
- flush_i=1 in any state: next state IDLE and counters cleared.
  - done_o and write enables are forced to 0 in the flush cycle.
  - busy_o is forced 0 during flush, so the flushed instruction does not hold the stall.
- done_o=0 and write enables=0 in IDLE except the MTHI/MTLO case.
- hi_o/lo_o are don't-care when done_o=0.
- valid_i with op NONE/7: no effect.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF, MUL_CYCLES=2:
  - busy_o=1 at T0 and T1;
  - T2: done_o=1, hi=0xFFFFFFFE, lo=0x00000001, both write enables=1;
  - T3: IDLE.
- MULT a=0xFFFFFFFD (-3) b=7: done at T2 with hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - Repeat with MUL_CYCLES=1: done at T1.
- DIV a=0xFFFFFFF9 (-7) b=2: busy_o=1 for T0..T32; T33 done with lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 100/7 -> lo=14, hi=2.
- Divide boundaries:
  - DIVU 5/0 -> lo=0xFFFFFFFF, hi=5;
  - DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- flush_i at T10 of a DIV:
  - busy_o=0 in T10; IDLE in T11; no done_o ever;
  - a MULT presented at T11 is accepted and completes at T13 with correct values.
- MTHI a=0x00001234 in IDLE: same-cycle done_o=1, hi_we_o=1, lo_we_o=0, hi_o=0x1234, busy_o=0.
  - resetn=0 at T5 of a DIV -> IDLE next cycle, all outputs 0, no done_o.
